// File: rtl/mema_row_loader.sv
// Matrix-A row loader: packs a valid/ready element stream into full memory rows and
// writes them to consecutive A-memory addresses. Optional MEMA_LOADER_CHECKSUM_EN adds a per-row XOR checksum.
module mema_row_loader #(
    parameter int NO_OF_ELEMENTS_ON_COL_NOS   = 20,
    parameter int NO_OF_ROW_BY_VECTOR_MODULES = 4,
    parameter int ELEMENT_WIDTH               = 32,
    parameter int TOTAL_ELEMS = NO_OF_ROW_BY_VECTOR_MODULES * NO_OF_ELEMENTS_ON_COL_NOS,
    parameter int ROW_WIDTH   = TOTAL_ELEMS * ELEMENT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [31:0]              base_addr_i,
    input  logic [31:0]              no_of_rows_i,
    input  logic                     in_valid_i,
    input  logic [ELEMENT_WIDTH-1:0] in_data_i,
    output logic                     in_ready_o,
    output logic                     mem_wr_en_o,
    output logic [31:0]              mem_wr_addr_o,
    output logic [ROW_WIDTH-1:0]     mem_wr_data_o,
    output logic                     busy_o,
`ifdef MEMA_LOADER_CHECKSUM_EN
    output logic [ELEMENT_WIDTH-1:0] row_checksum_o,
`endif
    output logic                     done_o
);

    localparam int ECW = (TOTAL_ELEMS > 1) ? $clog2(TOTAL_ELEMS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [31:0] base_q, base_d;
    logic [31:0] rows_q, rows_d;
    logic [31:0] row_cnt_q, row_cnt_d;
    logic [ECW-1:0] elem_cnt_q, elem_cnt_d;

    // Element 0 of a row ends up in the top slot, so the read path sees module 4 at the MSB.
    logic [TOTAL_ELEMS-1:0][ELEMENT_WIDTH-1:0] row_shift_q, row_shift_d;

    logic xfer;
    logic last_elem;
    logic last_row;

    assign xfer      = (state_q == S_FILL) && in_valid_i;
    assign last_elem = (elem_cnt_q == ECW'(TOTAL_ELEMS - 1));
    assign last_row  = (row_cnt_q == (rows_q - 32'd1));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (no_of_rows_i == 32'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (xfer && last_elem) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = last_row ? S_DONE : S_FILL;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q      <= '0;
            rows_q      <= '0;
            row_cnt_q   <= '0;
            elem_cnt_q  <= '0;
            row_shift_q <= '0;
        end else begin
            base_q      <= base_d;
            rows_q      <= rows_d;
            row_cnt_q   <= row_cnt_d;
            elem_cnt_q  <= elem_cnt_d;
            row_shift_q <= row_shift_d;
        end
    end

    always_comb begin
        base_d      = base_q;
        rows_d      = rows_q;
        row_cnt_d   = row_cnt_q;
        elem_cnt_d  = elem_cnt_q;
        row_shift_d = row_shift_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    rows_d     = no_of_rows_i;
                    row_cnt_d  = '0;
                    elem_cnt_d = '0;
                end
            end
            S_FILL: begin
                if (xfer) begin
                    row_shift_d = {row_shift_q[TOTAL_ELEMS-2:0], in_data_i};
                    elem_cnt_d  = last_elem ? '0 : elem_cnt_q + ECW'(1);
                end
            end
            S_WRITE: row_cnt_d = row_cnt_q + 32'd1;
            default: ;
        endcase
    end

`ifdef MEMA_LOADER_CHECKSUM_EN
    logic [ELEMENT_WIDTH-1:0] csum_q, csum_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    always_comb begin
        csum_d = csum_q;
        if (state_q == S_WRITE) begin
            csum_d = '0;
        end else if (xfer) begin
            csum_d = csum_q ^ in_data_i;
        end
    end

    assign row_checksum_o = (state_q == S_WRITE) ? csum_q : '0;
`endif

    // Output logic; address/data are forced to zero outside the write cycle
    always_comb begin
        in_ready_o    = 1'b0;
        mem_wr_en_o   = 1'b0;
        mem_wr_addr_o = '0;
        mem_wr_data_o = '0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        case (state_q)
            S_FILL: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
            end
            S_WRITE: begin
                mem_wr_en_o   = 1'b1;
                mem_wr_addr_o = base_q + row_cnt_q;
                mem_wr_data_o = row_shift_q;
                busy_o        = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mema_row_loader.sv
// Scoreboard bench for mema_row_loader: expected rows queued at stimulus time, checked on each write.
module tb_mema_row_loader;
    localparam int EW = 32;
    localparam int TE = 80;
    localparam int RW = TE * EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   base_addr;
    logic [31:0]   no_of_rows;
    logic          in_valid;
    logic [EW-1:0] in_data;
    logic          in_ready;
    logic          mem_wr_en;
    logic [31:0]   mem_wr_addr;
    logic [RW-1:0] mem_wr_data;
    logic          busy;
    logic          done;
`ifdef MEMA_LOADER_CHECKSUM_EN
    logic [EW-1:0] row_checksum;
`endif

    mema_row_loader dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .base_addr_i   (base_addr),
        .no_of_rows_i  (no_of_rows),
        .in_valid_i    (in_valid),
        .in_data_i     (in_data),
        .in_ready_o    (in_ready),
        .mem_wr_en_o   (mem_wr_en),
        .mem_wr_addr_o (mem_wr_addr),
        .mem_wr_data_o (mem_wr_data),
        .busy_o        (busy),
`ifdef MEMA_LOADER_CHECKSUM_EN
        .row_checksum_o(row_checksum),
`endif
        .done_o        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   addr;
        logic [RW-1:0] data;
        logic [EW-1:0] csum;
    } wr_t;

    wr_t exp_q[$];
    int  wr_cyc_q[$];
    int  done_cyc_q[$];
    bit  rdy_seen;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Expected row: element e (arrival order) with value vals[e] sits at [(TE-e)*EW-1 -: EW]
    function automatic logic [RW-1:0] row_seq(input logic [EW-1:0] first);
        logic [RW-1:0] d;
        d = '0;
        for (int e = 0; e < TE; e++) d[(TE-e)*EW-1 -: EW] = first + EW'(e);
        return d;
    endfunction

    function automatic logic [EW-1:0] csum_seq(input logic [EW-1:0] first);
        logic [EW-1:0] c;
        c = '0;
        for (int e = 0; e < TE; e++) c = c ^ (first + EW'(e));
        return c;
    endfunction

    // Write monitor: pops the scoreboard on every write strobe
    always @(negedge clk) begin
        wr_t e;
        int  bad;
        if (in_ready) rdy_seen = 1'b1;
        if (done) done_cyc_q.push_back(cyc);
        if (mem_wr_en) begin
            wr_cyc_q.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr got=%h expected no write", mem_wr_addr);
            end else begin
                e = exp_q.pop_front();
                if (mem_wr_addr !== e.addr) begin
                    n_fail++;
                    $display("FAIL wr_addr got=%h expected=%h", mem_wr_addr, e.addr);
                end
                n_checks++;
                if (mem_wr_data !== e.data) begin
                    bad = 0;
                    for (int i = 0; i < TE; i++)
                        if (mem_wr_data[i*EW +: EW] !== e.data[i*EW +: EW]) bad = i;
                    n_fail++;
                    $display("FAIL wr_data addr=%h slot %0d got=%h expected=%h", e.addr, bad,
                             mem_wr_data[bad*EW +: EW], e.data[bad*EW +: EW]);
                end
`ifdef MEMA_LOADER_CHECKSUM_EN
                n_checks++;
                if (row_checksum !== e.csum) begin
                    n_fail++;
                    $display("FAIL row_checksum got=%h expected=%h", row_checksum, e.csum);
                end
`endif
            end
        end
    end

    task automatic start_load(input logic [31:0] b, input logic [31:0] n, output int st);
        start = 1'b1; base_addr = b; no_of_rows = n;
        @(negedge clk); st = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive one element until accepted; t is the cycle in which the transfer is visible
    task automatic feed(input logic [EW-1:0] v, input bit gap, output int t);
        int k;
        bit rdy;
        k = 0; rdy = 1'b0; t = -1;
        in_valid = 1'b1; in_data = v;
        while (!rdy && k < 200) begin
            @(negedge clk); rdy = in_ready; t = cyc;
            @(posedge clk); #1;
            k++;
        end
        if (!rdy) begin
            n_checks++; n_fail++;
            $display("FAIL feed_timeout element=%h got no in_ready expected in_ready", v);
        end
        in_valid = 1'b0;
        if (gap) begin
            in_data = 32'hDEAD_BEEF;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(output int dc);
        int k;
        k = 0;
        while (done_cyc_q.size() == 0 && k < 500) begin
            @(posedge clk); k++;
        end
        if (done_cyc_q.size() == 0) begin
            dc = -1;
            n_checks++; n_fail++;
            $display("FAIL done_timeout got no done expected done");
        end else begin
            dc = done_cyc_q.pop_front();
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        base_addr = '0; no_of_rows = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b expected=0", in_ready); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b expected=0", mem_wr_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b expected=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b expected=0", done); end
        n_checks++; if (mem_wr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h expected=0", mem_wr_addr); end
        n_checks++; if (mem_wr_data !== '0) begin n_fail++; $display("FAIL reset_data got_nonzero=%b expected=0", |mem_wr_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_two_row();
        int st, t, t80, dc;
        wr_cyc_q.delete(); done_cyc_q.delete();
        exp_q.push_back('{32'h10, row_seq(32'h1),  csum_seq(32'h1)});
        exp_q.push_back('{32'h11, row_seq(32'h51), csum_seq(32'h51)});
        start_load(32'h10, 32'd2, st);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL two_row_busy got=%b expected=1", busy); end
        @(posedge clk); #1;
        t80 = -1;
        for (int v = 1; v <= 160; v++) begin
            feed(EW'(v), 1'b0, t);
            if (v == 80) t80 = t;
        end
        wait_done(dc);
        n_checks++; if (dc !== t + 2) begin n_fail++; $display("FAIL two_row_done_cycle got=%0d expected=%0d", dc, t + 2); end
        n_checks++; if (wr_cyc_q.size() !== 2) begin n_fail++; $display("FAIL two_row_writes got=%0d expected=2", wr_cyc_q.size()); end
        else begin
            n_checks++; if (wr_cyc_q[0] !== t80 + 1) begin n_fail++; $display("FAIL two_row_wr0_cycle got=%0d expected=%0d", wr_cyc_q[0], t80 + 1); end
            n_checks++; if (wr_cyc_q[1] !== t + 1) begin n_fail++; $display("FAIL two_row_wr1_cycle got=%0d expected=%0d", wr_cyc_q[1], t + 1); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL two_row_busy_after got=%b expected=0", busy); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL two_row_pending got=%0d expected=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_backpressure();
        int st, t, t80, dc;
        wr_cyc_q.delete(); done_cyc_q.delete();
        exp_q.push_back('{32'h10, row_seq(32'h1),  csum_seq(32'h1)});
        exp_q.push_back('{32'h11, row_seq(32'h51), csum_seq(32'h51)});
        start_load(32'h10, 32'd2, st);
        t80 = -1;
        for (int v = 1; v <= 160; v++) begin
            feed(EW'(v), 1'b1, t);
            if (v == 80) t80 = t;
        end
        wait_done(dc);
        n_checks++; if (dc !== t + 2) begin n_fail++; $display("FAIL bp_done_cycle got=%0d expected=%0d", dc, t + 2); end
        n_checks++; if (wr_cyc_q.size() !== 2) begin n_fail++; $display("FAIL bp_writes got=%0d expected=2", wr_cyc_q.size()); end
        else begin
            n_checks++; if (wr_cyc_q[0] !== t80 + 1) begin n_fail++; $display("FAIL bp_wr0_cycle got=%0d expected=%0d", wr_cyc_q[0], t80 + 1); end
        end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL bp_pending got=%0d expected=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid();
        int st, t, dc;
        wr_cyc_q.delete(); done_cyc_q.delete();
        start_load(32'h30, 32'd1, st);
        for (int v = 0; v < 37; v++) feed(32'h200 + EW'(v), 1'b0, t);
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready got=%b expected=0", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b expected=0", busy); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr_en got=%b expected=0", mem_wr_en); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back('{32'h40, row_seq(32'h300), csum_seq(32'h300)});
        start_load(32'h40, 32'd1, st);
        for (int v = 0; v < 80; v++) feed(32'h300 + EW'(v), 1'b0, t);
        wait_done(dc);
        n_checks++; if (dc !== t + 2) begin n_fail++; $display("FAIL rstmid_done_cycle got=%0d expected=%0d", dc, t + 2); end
        n_checks++; if (wr_cyc_q.size() !== 1) begin n_fail++; $display("FAIL rstmid_writes got=%0d expected=1", wr_cyc_q.size()); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_pending got=%0d expected=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_zero_rows();
        int st;
        wr_cyc_q.delete(); done_cyc_q.delete();
        rdy_seen = 1'b0;
        start_load(32'h55, 32'd0, st);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL zero_done_count got=%0d expected=1", done_cyc_q.size()); end
        else begin
            n_checks++; if (done_cyc_q[0] !== st + 1) begin n_fail++; $display("FAIL zero_done_cycle got=%0d expected=%0d", done_cyc_q[0], st + 1); end
        end
        n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready got=%b expected=0", rdy_seen); end
        n_checks++; if (wr_cyc_q.size() !== 0) begin n_fail++; $display("FAIL zero_writes got=%0d expected=0", wr_cyc_q.size()); end
        done_cyc_q.delete();
    endtask

    task automatic test_start_busy();
        int st, t, dc;
        wr_cyc_q.delete(); done_cyc_q.delete();
        exp_q.push_back('{32'h20, row_seq(32'h400), csum_seq(32'h400)});
        exp_q.push_back('{32'h21, row_seq(32'h450), csum_seq(32'h450)});
        start_load(32'h20, 32'd2, st);
        for (int v = 0; v < 10; v++) feed(32'h400 + EW'(v), 1'b0, t);
        start = 1'b1; base_addr = 32'h99; no_of_rows = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int v = 10; v < 160; v++) feed(32'h400 + EW'(v), 1'b0, t);
        wait_done(dc);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (wr_cyc_q.size() !== 2) begin n_fail++; $display("FAIL sbusy_writes got=%0d expected=2", wr_cyc_q.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sbusy_busy_after got=%b expected=0", busy); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sbusy_pending got=%0d expected=0", exp_q.size()); exp_q.delete(); end
    endtask

`ifdef MEMA_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int st, t, dc;
        logic [RW-1:0] ones;
        wr_cyc_q.delete(); done_cyc_q.delete();
        ones = '0;
        for (int e = 0; e < TE; e++) ones[e*EW +: EW] = 32'h1;
        exp_q.push_back('{32'h60, ones, 32'h0});
        exp_q.push_back('{32'h61, row_seq(32'h1), 32'h50});
        start_load(32'h60, 32'd2, st);
        for (int v = 0; v < 80; v++) feed(32'h1, 1'b0, t);
        for (int v = 1; v <= 80; v++) feed(EW'(v), 1'b0, t);
        wait_done(dc);
        n_checks++; if (wr_cyc_q.size() !== 2) begin n_fail++; $display("FAIL csum_writes got=%0d expected=2", wr_cyc_q.size()); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL csum_pending got=%0d expected=0", exp_q.size()); exp_q.delete(); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_two_row();
        test_backpressure();
        test_reset_mid();
        test_zero_rows();
        test_start_busy();
`ifdef MEMA_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
